// File: rtl/sort_ctrl_if.sv
// Host and RAM signal bundle for sort_ctrl.
// The slave view belongs to the controller; master is the host/RAM side.
interface sort_ctrl_if #(
   parameter int N = 16,
   parameter int L = 4
);
   logic         start;
   logic         WrInit;
   logic         Rd;
   logic [L-1:0] RAddr;
   logic [N-1:0] DataIn;
   logic [N-1:0] DataOut;
   logic         done;
   logic         busy;
   logic [L-1:0] mem_addr;
   logic         mem_we;
   logic [N-1:0] mem_wdata;
   logic [N-1:0] mem_rdata;

   modport master (
      output start, WrInit, Rd, RAddr, DataIn, mem_rdata,
      input  DataOut, done, busy, mem_addr, mem_we, mem_wdata
   );

   modport slave (
      input  start, WrInit, Rd, RAddr, DataIn, mem_rdata,
      output DataOut, done, busy, mem_addr, mem_we, mem_wdata
   );
endinterface

// File: rtl/sort_ctrl.sv
// In-place ascending selection sort sequencer for an external 2^L-word RAM
// with a combinational read port; host access is allowed only when not busy.
//
// state | meaning
// IDLE  | host port owns the RAM, waiting for start
// LOAD  | read word i, it becomes the running minimum
// SCAN  | compare word j against the running minimum
// SWAP1 | write the old word i to the minimum's slot
// SWAP2 | write the minimum to slot i, advance i
// DONE  | sort complete, host port owns the RAM until start drops
module sort_ctrl #(
   parameter int N = 16,
   parameter int L = 4
) (
   input  logic        clk,
   input  logic        rst,
   sort_ctrl_if.slave  bus
);
   typedef enum logic [2:0] {IDLE, LOAD, SCAN, SWAP1, SWAP2, DONE} state_t;

   localparam logic [L-1:0] J_LAST = {L{1'b1}};
   localparam logic [L-1:0] I_LAST = J_LAST - 1'b1;

   state_t       state, state_nx;
   logic [L-1:0] i_q, i_nx, j_q, j_nx, minidx_q, minidx_nx;
   logic [N-1:0] minval_q, minval_nx, ival_q, ival_nx, dout_q, dout_nx;
   logic [L-1:0] addr;
   logic         we;
   logic [N-1:0] wdata;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         i_q      <= '0;
         j_q      <= '0;
         minidx_q <= '0;
         minval_q <= '0;
         ival_q   <= '0;
         dout_q   <= '0;
      end else begin
         state    <= state_nx;
         i_q      <= i_nx;
         j_q      <= j_nx;
         minidx_q <= minidx_nx;
         minval_q <= minval_nx;
         ival_q   <= ival_nx;
         dout_q   <= dout_nx;
      end
   end

   always_comb begin
      state_nx  = state;
      i_nx      = i_q;
      j_nx      = j_q;
      minidx_nx = minidx_q;
      minval_nx = minval_q;
      ival_nx   = ival_q;
      dout_nx   = dout_q;
      addr      = bus.RAddr;
      we        = 1'b0;
      wdata     = '0;
      case (state)
         IDLE: begin
            // start takes priority over a same-cycle host write
            if (bus.start) begin
               state_nx = LOAD;
               i_nx     = '0;
            end else if (bus.WrInit) begin
               we    = 1'b1;
               wdata = bus.DataIn;
            end
            if (bus.Rd) dout_nx = bus.mem_rdata;
         end
         LOAD: begin
            addr      = i_q;
            ival_nx   = bus.mem_rdata;
            minval_nx = bus.mem_rdata;
            minidx_nx = i_q;
            j_nx      = i_q + 1'b1;
            state_nx  = SCAN;
         end
         SCAN: begin
            addr = j_q;
            if (bus.mem_rdata < minval_q) begin
               minval_nx = bus.mem_rdata;
               minidx_nx = j_q;
            end
            if (j_q == J_LAST) state_nx = SWAP1;
            else               j_nx     = j_q + 1'b1;
         end
         SWAP1: begin
            addr     = minidx_q;
            we       = 1'b1;
            wdata    = ival_q;
            state_nx = SWAP2;
         end
         SWAP2: begin
            addr  = i_q;
            we    = 1'b1;
            wdata = minval_q;
            if (i_q == I_LAST) begin
               state_nx = DONE;
            end else begin
               i_nx     = i_q + 1'b1;
               state_nx = LOAD;
            end
         end
         DONE: begin
            if (bus.WrInit) begin
               we    = 1'b1;
               wdata = bus.DataIn;
            end
            if (bus.Rd)     dout_nx  = bus.mem_rdata;
            if (!bus.start) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   assign bus.mem_addr  = addr;
   assign bus.mem_we    = we;
   assign bus.mem_wdata = wdata;
   assign bus.DataOut   = dout_q;
   assign bus.done      = (state == DONE);
   assign bus.busy      = (state == LOAD) || (state == SCAN) ||
                          (state == SWAP1) || (state == SWAP2);
endmodule

// File: tb/tb_sort_ctrl.sv
// Self-checking bench for sort_ctrl: behavioural RAM, queue-sort reference,
// directed and random arrays.
module tb_sort_ctrl;
   localparam int N = 16;
   localparam int L = 4;
   localparam int M = 16;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   sort_ctrl_if #(.N(N), .L(L)) bus();
   sort_ctrl #(.N(N), .L(L)) dut (.clk(clk), .rst(rst), .bus(bus));

   logic [N-1:0] ram [M];
   assign bus.mem_rdata = ram[bus.mem_addr];
   always @(posedge clk) if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;

   int           n_vec = 0;
   int           n_err = 0;
   logic [N-1:0] src [M];
   logic [N-1:0] golden [$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic host_write(input logic [L-1:0] a, input logic [N-1:0] d);
      @(negedge clk);
      bus.WrInit = 1'b1;
      bus.RAddr  = a;
      bus.DataIn = d;
      @(negedge clk);
      bus.WrInit = 1'b0;
   endtask

   task automatic host_read(input logic [L-1:0] a, output logic [N-1:0] d);
      @(negedge clk);
      bus.Rd    = 1'b1;
      bus.RAddr = a;
      @(negedge clk);
      bus.Rd = 1'b0;
      d = bus.DataOut;
   endtask

   task automatic load_src();
      golden.delete();
      for (int k = 0; k < M; k++) begin
         host_write(k[L-1:0], src[k]);
         golden.push_back(src[k]);
      end
      golden.sort();
   endtask

   task automatic random_src();
      for (int k = 0; k < M; k++) src[k] = N'($urandom_range(0, 16'hFFFE));
   endtask

   task automatic verify(input string tag);
      logic [N-1:0] d;
      for (int k = 0; k < M; k++) begin
         host_read(k[L-1:0], d);
         check(tag, {16'd0, d}, {16'd0, golden[k]});
      end
   endtask

   // Raises start (and releases reset) at a negedge, then counts rising edges
   // until done; counts write cycles issued while busy.
   task automatic run_sort(input bit hold, input bit intrude, input bit with_wr,
                           input int abort_at, output int edges, output int wes);
      logic [N-1:0] dout0;
      bit           fin;
      edges = 0;
      wes   = 0;
      fin   = 1'b0;
      @(negedge clk);
      rst       = 1'b1;
      dout0     = bus.DataOut;
      bus.start = 1'b1;
      if (with_wr) begin
         bus.WrInit = 1'b1;
         bus.RAddr  = 4'd3;
         bus.DataIn = 16'hBEEF;
         #1 check("start_beats_wr", {31'd0, bus.mem_we}, 32'd0);
      end
      while (!fin && edges < 400) begin
         @(posedge clk);
         edges++;
         @(negedge clk);
         if (edges == 1) begin
            bus.WrInit = 1'b0;
            if (with_wr) check("busy_after_start", {31'd0, bus.busy}, 32'd1);
            if (!hold) bus.start = 1'b0;
         end
         if (intrude && edges == 20) begin
            bus.WrInit = 1'b1;
            bus.Rd     = 1'b1;
            bus.RAddr  = 4'd5;
            bus.DataIn = 16'hFFFF;
         end else if (intrude && edges == 30) begin
            bus.WrInit = 1'b0;
            bus.Rd     = 1'b0;
         end
         if (bus.busy && bus.mem_we) wes++;
         check("done_busy_excl", {31'd0, bus.done & bus.busy}, 32'd0);
         if (edges == abort_at) begin
            rst = 1'b0;
            #1;
            check("abort_busy", {31'd0, bus.busy}, 32'd0);
            check("abort_done", {31'd0, bus.done}, 32'd0);
            check("abort_dout", {16'd0, bus.DataOut}, 32'd0);
            fin = 1'b1;
         end
         if (bus.done) fin = 1'b1;
      end
      check("sort_timeout", {31'd0, fin}, 32'd1);
      if (intrude) check("dataout_hold", {16'd0, bus.DataOut}, {16'd0, dout0});
   endtask

   initial begin
      int           e, w;
      logic [N-1:0] d;
      logic [N-1:0] s1 [M] = '{45, 12, 78, 34, 56, 89, 23, 67, 44, 101, 10, 2, 9, 90, 11, 66};
      bus.start  = 1'b0;
      bus.WrInit = 1'b0;
      bus.Rd     = 1'b0;
      bus.RAddr  = '0;
      bus.DataIn = '0;
      #12;
      check("rst_done", {31'd0, bus.done}, 32'd0);
      check("rst_busy", {31'd0, bus.busy}, 32'd0);
      check("rst_dout", {16'd0, bus.DataOut}, 32'd0);
      check("rst_we",   {31'd0, bus.mem_we}, 32'd0);
      rst = 1'b1;

      // directed array
      src = s1;
      load_src();
      run_sort(0, 0, 0, 0, e, w);
      check("s1_latency", e, 166);
      check("s1_we_cnt", w, 30);
      verify("s1_data");

      // duplicates
      for (int k = 0; k < M; k++) src[k] = (k % 2 == 0) ? 16'd7 : 16'd3;
      load_src();
      run_sort(0, 0, 0, 0, e, w);
      check("dup_latency", e, 166);
      check("dup_we_cnt", w, 30);
      verify("dup_data");

      // host write/read while busy
      random_src();
      load_src();
      host_read(4'd9, d);
      run_sort(0, 1, 0, 0, e, w);
      check("busy_wr_latency", e, 166);
      verify("busy_wr_data");

      // hold start after done, then re-sort sorted data
      random_src();
      load_src();
      run_sort(1, 0, 0, 0, e, w);
      check("hold_latency", e, 166);
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         check("hold_done", {31'd0, bus.done}, 32'd1);
         check("hold_busy", {31'd0, bus.busy}, 32'd0);
      end
      verify("hold_data");
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      check("drop_done", {31'd0, bus.done}, 32'd0);
      check("drop_busy", {31'd0, bus.busy}, 32'd0);
      run_sort(0, 0, 0, 0, e, w);
      check("resort_latency", e, 166);
      verify("resort_data");

      // reset mid-SCAN, leave reset with start high, full new sort
      random_src();
      load_src();
      run_sort(0, 0, 0, 40, e, w);
      run_sort(0, 0, 0, 0, e, w);
      check("post_rst_latency", e, 166);
      verify("post_rst_data");

      // start and WrInit together in IDLE
      random_src();
      load_src();
      run_sort(0, 0, 1, 0, e, w);
      check("sw_latency", e, 166);
      verify("sw_data");

      // extra random arrays, including narrow value ranges for ties
      for (int r = 0; r < 3; r++) begin
         for (int k = 0; k < M; k++)
            src[k] = (r == 0) ? N'($urandom_range(0, 3)) : N'($urandom_range(0, 16'hFFFE));
         load_src();
         run_sort(0, 0, 0, 0, e, w);
         check("rnd_latency", e, 166);
         check("rnd_we_cnt", w, 30);
         verify("rnd_data");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/sort_ctrl.md
SORT_CTRL -- requirements
Module: sort_ctrl

Interface
REQ-001 Parameters SHALL be, one per line:
- N, 16, data word width in bits
- L, 4, address width; array depth M = 2^L words; legal range L >= 2
REQ-002 Ports SHALL be, one per line:
- clk  input  1  single clock; all state updates on its rising edge
- rst  input  1  asynchronous, active-low reset
- start  input  1  level request to sort the whole array
- WrInit  input  1  host write strobe (idle only)
- Rd  input  1  host read strobe (idle only)
- RAddr  input  L  host word address
- DataIn  input  N  host write data
- DataOut  output  N  registered host read data
- done  output  1  sort complete
- busy  output  1  sort in progress
- mem_addr  output  L  RAM address
- mem_we  output  1  RAM write enable
- mem_wdata  output  N  RAM write data
- mem_rdata  input  N  RAM read data, combinational (same-cycle) read of mem_addr

Function
REQ-003 Block SHALL sequence an in-place ascending unsigned selection sort of the external M-word RAM.
REQ-004 FSM states SHALL be IDLE, LOAD, SCAN, SWAP1, SWAP2, DONE.
REQ-005 IDLE: on start=1, go to LOAD with i=0. Otherwise stay.
REQ-006 LOAD (1 cycle): mem_addr=i; latch ival=minval=mem_rdata, minidx=i; set j=i+1; go to SCAN.
REQ-007 SCAN (1 cycle per j): mem_addr=j.
- If mem_rdata < minval (strict, unsigned): minval<=mem_rdata, minidx<=j.
- If j==M-1, go to SWAP1; else j<=j+1.
REQ-008 SWAP1: mem_addr=minidx, mem_we=1, mem_wdata=ival; go to SWAP2.
REQ-009 SWAP2: mem_addr=i, mem_we=1, mem_wdata=minval.
- If i==M-2, go to DONE; else i<=i+1 and go to LOAD.
- Both swap cycles SHALL always execute, including when minidx==i.
REQ-010 Ties SHALL keep the lowest-index minimum (strict compare).
REQ-011 Latency: sort work SHALL take exactly 3(M-1)+M(M-1)/2 cycles (165 for M=16).
- done SHALL assert on the 166th rising edge counting the edge that samples start in IDLE as the first.
REQ-012 DONE: done=1. Stay while start=1; return to IDLE on the first edge with start=0.
REQ-013 busy SHALL be 1 in LOAD, SCAN, SWAP1 and SWAP2, and 0 otherwise. done and busy SHALL never both be 1.
REQ-014 Host port in IDLE and DONE:
- mem_addr=RAddr, mem_we=WrInit, mem_wdata=DataIn.
- When Rd=1, DataOut<=mem_rdata at the edge (1-cycle read latency); otherwise DataOut holds.
REQ-015 While busy:
- WrInit SHALL be ignored and never reach mem_we.
- Rd SHALL be ignored; DataOut holds.
REQ-016 In IDLE, start=1 with WrInit=1 in the same cycle: start SHALL win; the write SHALL be dropped (mem_we=0).
REQ-017 In non-write cycles, mem_we SHALL be 0 and mem_wdata SHALL be 0.
REQ-018 i and j SHALL never wrap: j never exceeds M-1, i never exceeds M-2.

Reset
REQ-019 rst=0 SHALL immediately force:
- state=IDLE, done=0, busy=0, DataOut=0, mem_we=0
- i, j, minidx, minval and ival to 0
REQ-020 Reset mid-sort SHALL abort the sort without restoring RAM; the next start SHALL perform a full new sort.
REQ-021 Leaving reset with start=1 SHALL begin a sort on the first edge after rst rises.

Verification
REQ-022 Bench SHALL cover these scenarios:
- Load 45,12,78,34,56,89,23,67,44,101,10,2,9,90,11,66; pulse start high -> done after exactly 166 edges; read-back 2,9,10,11,12,23,34,44,45,56,66,67,78,89,90,101.
- Duplicates 7,3,7,3,... (M=16) -> read-back eight 3s then eight 7s; mem_we high exactly 30 cycles during the sort.
- WrInit=1 at address 5 with value 0xFFFF during busy -> RAM[5] unchanged by host; DataOut holds across a Rd during busy.
- Hold start=1 after done -> done stays 1 with no re-sort; drop start -> IDLE; re-raise start -> sort again (already sorted data unchanged).
- Assert rst mid-SCAN (cycle 40) -> busy=0, done=0 immediately; new start -> correct sorted result.
- Set start and WrInit together in IDLE -> no RAM write; busy=1 next cycle.
